cart_backup: RTL
================

// Module: cart_backup
// PURPOSE
//  Battery-backed cart RAM save/load streamer between the active mapper's cart RAM (the 17-bit
//  cram address space that mmm01/mbc* select) and the HPS SD block interface. Copies RAM to/from
//  the mounted save image in 512-byte sectors. Tracks CPU writes (dirty) so clean RAM is not saved.
//  Owns the second port of the cart RAM; the CPU port is untouched.
// PARAMETERS
//  ACK_TIMEOUT  24'hFFFFFF  clk_sys cycles to wait for sd_ack before aborting with err
// PORTS
//  clk_sys       in   1   system clock
//  reset_n       in   1   asynchronous, active-low reset
//  has_battery   in   1   cart has battery RAM; 0 = every request ignored
//  ram_sectors   in   9   cart RAM size in 512 B sectors, 1..256
//  img_mounted   in   1   save image mounted, 1-cycle pulse
//  img_readonly  in   1   image write-protected; saves rejected
//  img_size      in  32   image size in bytes
//  bk_load       in   1   load request pulse
//  bk_save       in   1   save request pulse
//  cpu_ram_wr    in   1   CPU write strobe to cart RAM; sets dirty
//  sd_lba        out 32   sector index being transferred
//  sd_rd         out  1   sector read request (image -> RAM)
//  sd_wr         out  1   sector write request (RAM -> image)
//  sd_ack        in   1   HPS owns the buffer while high
//  sd_buff_addr  in   9   byte offset within sector
//  sd_buff_dout  in   8   load data from HPS
//  sd_buff_wr    in   1   load data strobe
//  sd_buff_din   out  8   save data to HPS (= ram_do)
//  ram_addr      out 17   cart RAM port-B address
//  ram_we        out  1   cart RAM port-B write enable
//  ram_di        out  8   cart RAM port-B write data
//  ram_do        in   8   cart RAM port-B read data, 1-cycle latency
//  busy          out  1   transfer in progress
//  dirty         out  1   RAM modified since last load/save
//  err           out  1   sticky: last op timed out; cleared at next op start
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; pending flags 0. Mid-transfer reset drops sd_rd/sd_wr at once.
//  Requests: bk_load and bk_save set one-deep pending flags, also while busy.
//   - img_mounted with img_size!=0 sets pending load.
//   - Load beats save when both are pending in IDLE.
//   - Save with dirty=0 or img_readonly=1 is discarded without a transfer.
//   - has_battery=0 clears both pending flags.
//  Sector count N:
//   - load: N = min(ram_sectors, img_size[31:9]); N=0 -> no transfer.
//   - save: N = ram_sectors.
//  FSM:
//   - IDLE -> REQ when a pending op is accepted; sd_lba=0; err cleared.
//   - REQ: drive sd_rd/sd_wr. sd_ack=1 -> XFER. Timer hits ACK_TIMEOUT -> IDLE, err=1.
//   - XFER: sd_rd/sd_wr drop on the first ack cycle. sd_ack falling -> GAP.
//   - GAP: if sd_lba==N-1 -> IDLE, op done; else sd_lba+1 -> REQ.
//  Datapath:
//   - ram_addr = {sd_lba[7:0], sd_buff_addr}, registered.
//   - Load: ram_we = sd_buff_wr & sd_ack & load, 1 cycle after strobe, ram_di = sd_buff_dout.
//     ram_we never asserted outside XFER.
//   - Save: sd_buff_din = ram_do. HPS holds sd_buff_addr >= 3 cycles, covering address+read latency.
//  Dirty:
//   - set by cpu_ram_wr any time, including mid-save.
//   - cleared when a load completes, or when a save completes with no CPU write during the save.
//   - a write during a save keeps dirty=1.
//  busy = FSM != IDLE. sd_lba wraps never: N <= 256.
// STRUCTURE
//  Shared package gb_pkg: FSM state enum, SECTOR_BYTES=512, RAM_ADDR_W=17.
//  No sub-module. Timeout counter and pending/dirty logic are inline.
// TESTING
//  1 ram_sectors=4, img_size=2048, pulse img_mounted -> 4 sd_rd sectors, lba 0..3.
//    RAM[0x3FF]=image byte 1023; dirty=0 at end.
//  2 cpu_ram_wr, then bk_save -> 4 sd_wr sectors, sd_buff_din matches RAM; dirty=0 after.
//    bk_save again -> no sd_wr.
//  3 bk_load+bk_save same cycle (dirty=1) -> full load, then full save; busy high throughout.
//  4 sd_ack held low -> after ACK_TIMEOUT (set 16 in bench) err=1, sd_rd=0, busy=0.
//  5 img_readonly=1, dirty=1, bk_save -> no transfer, dirty stays 1.
//    cpu_ram_wr during a save -> dirty=1 after.
//  6 reset_n low in XFER sector 2 -> sd_rd/sd_wr/busy/ram_we 0 same cycle; pending flags cleared.

Source files
------------

// File: rtl/gb_pkg.sv
// Shared definitions for the cart RAM backup streamer.
//   bk_state_e   : transfer sequencer states
//   SECTOR_BYTES : bytes per SD sector
//   RAM_ADDR_W   : cart RAM address width (17-bit cram space)
//   load_sectors : sectors to copy on a load, min(ram_sectors, img_size/512)
package gb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_GAP  = 2'd3
    } bk_state_e;

    localparam int SECTOR_BYTES = 512;
    localparam int RAM_ADDR_W   = 17;

    function automatic logic [8:0] load_sectors(input logic [8:0]  ram_sectors,
                                                input logic [22:0] img_sectors);
        // When the image is smaller than the RAM it is below 256, so it fits in 9 bits.
        if (img_sectors < {14'd0, ram_sectors})
            load_sectors = img_sectors[8:0];
        else
            load_sectors = ram_sectors;
    endfunction

endpackage

// File: rtl/cart_backup.sv
// Battery-backed cart RAM save/load streamer.
// Copies the cart RAM (port B) to or from the mounted save image, one 512-byte
// sector at a time, over the HPS SD block interface. Tracks CPU writes so that a
// clean RAM is never written back.
// Ports:
//   clk_sys, reset_n              clock, async active-low reset
//   has_battery, ram_sectors      cart configuration
//   img_mounted/readonly/size     save image status
//   bk_load, bk_save              request pulses
//   cpu_ram_wr                    CPU write strobe (marks RAM dirty)
//   sd_lba, sd_rd, sd_wr, sd_ack  SD sector handshake
//   sd_buff_addr/dout/wr/din      SD buffer byte stream
//   ram_addr/we/di/do             cart RAM port B
//   busy, dirty, err              status
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no transfer; pending requests are accepted here
// ST_REQ  | sd_rd/sd_wr raised for sd_lba, waiting for sd_ack (timed)
// ST_XFER | HPS owns the buffer; bytes stream while sd_ack is high
// ST_GAP  | sector done; start next sector or finish the operation
module cart_backup
    import gb_pkg::*;
#(
    parameter logic [23:0] ACK_TIMEOUT = 24'hFFFFFF
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic                  has_battery,
    input  logic [8:0]            ram_sectors,
    input  logic                  img_mounted,
    input  logic                  img_readonly,
    input  logic [31:0]           img_size,
    input  logic                  bk_load,
    input  logic                  bk_save,
    input  logic                  cpu_ram_wr,
    output logic [31:0]           sd_lba,
    output logic                  sd_rd,
    output logic                  sd_wr,
    input  logic                  sd_ack,
    input  logic [8:0]            sd_buff_addr,
    input  logic [7:0]            sd_buff_dout,
    input  logic                  sd_buff_wr,
    output logic [7:0]            sd_buff_din,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic                  ram_we,
    output logic [7:0]            ram_di,
    input  logic [7:0]            ram_do,
    output logic                  busy,
    output logic                  dirty,
    output logic                  err
);

    bk_state_e             state_q;
    logic [31:0]           sd_lba_q;
    logic                  sd_rd_q, sd_wr_q;
    logic [23:0]           timer_q;
    logic [8:0]            n_q;
    logic                  op_load_q;
    logic                  err_q;
    logic                  dirty_q, dirty_d;
    logic                  save_hit_q;
    logic                  pend_load_q, pend_load_d;
    logic                  pend_save_q, pend_save_d;
    logic [RAM_ADDR_W-1:0] ram_addr_q;
    logic                  ram_we_q;
    logic [7:0]            ram_di_q;

    logic       last_sector;
    logic       op_done;
    logic       free;
    logic       take_load, take_save;
    logic       start_load, start_save, start_any;
    logic [8:0] load_n;

    assign last_sector = (sd_lba_q[8:0] == (n_q - 9'd1));
    assign op_done     = (state_q == ST_GAP) && last_sector;
    // Accepting straight out of the final GAP keeps busy high across chained ops.
    assign free        = (state_q == ST_IDLE) || op_done;
    assign load_n      = load_sectors(ram_sectors, img_size[31:9]);

    assign take_load   = free && has_battery && pend_load_q;
    assign take_save   = free && has_battery && !pend_load_q && pend_save_q;
    assign start_load  = take_load && (load_n != 9'd0);
    assign start_save  = take_save && !img_readonly && (ram_sectors != 9'd0);
    assign start_any   = start_load || start_save;

    // A save is only worth queuing if there is something to write and somewhere to write it.
    always_comb begin
        pend_load_d = 1'b0;
        pend_save_d = 1'b0;
        if (has_battery) begin
            pend_load_d = (pend_load_q && !take_load) || bk_load ||
                          (img_mounted && (img_size != 32'd0));
            pend_save_d = (pend_save_q && !take_save) ||
                          (bk_save && (dirty_q || cpu_ram_wr) && !img_readonly);
        end
    end

    always_comb begin
        dirty_d = dirty_q;
        if (cpu_ram_wr)
            dirty_d = 1'b1;
        else if (op_done && (op_load_q || !save_hit_q))
            dirty_d = 1'b0;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            sd_lba_q    <= 32'd0;
            sd_rd_q     <= 1'b0;
            sd_wr_q     <= 1'b0;
            timer_q     <= 24'd0;
            n_q         <= 9'd0;
            op_load_q   <= 1'b0;
            err_q       <= 1'b0;
            dirty_q     <= 1'b0;
            save_hit_q  <= 1'b0;
            pend_load_q <= 1'b0;
            pend_save_q <= 1'b0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_di_q    <= 8'd0;
        end else begin
            pend_load_q <= pend_load_d;
            pend_save_q <= pend_save_d;
            dirty_q     <= dirty_d;

            ram_addr_q  <= {sd_lba_q[7:0], sd_buff_addr};
            ram_di_q    <= sd_buff_dout;
            ram_we_q    <= (state_q == ST_XFER) && op_load_q && sd_ack && sd_buff_wr;

            if (start_any)
                save_hit_q <= 1'b0;
            else if (cpu_ram_wr && (state_q != ST_IDLE) && !op_load_q)
                save_hit_q <= 1'b1;

            if (start_any) begin
                state_q   <= ST_REQ;
                sd_lba_q  <= 32'd0;
                err_q     <= 1'b0;
                op_load_q <= start_load;
                n_q       <= start_load ? load_n : ram_sectors;
                sd_rd_q   <= start_load;
                sd_wr_q   <= !start_load;
                timer_q   <= ACK_TIMEOUT - 24'd1;
            end else begin
                case (state_q)
                    ST_IDLE: ;
                    ST_REQ: begin
                        if (sd_ack) begin
                            state_q <= ST_XFER;
                            sd_rd_q <= 1'b0;
                            sd_wr_q <= 1'b0;
                        end else if (timer_q == 24'd0) begin
                            state_q <= ST_IDLE;
                            sd_rd_q <= 1'b0;
                            sd_wr_q <= 1'b0;
                            err_q   <= 1'b1;
                        end else begin
                            timer_q <= timer_q - 24'd1;
                        end
                    end
                    ST_XFER: begin
                        if (!sd_ack)
                            state_q <= ST_GAP;
                    end
                    ST_GAP: begin
                        if (last_sector) begin
                            state_q <= ST_IDLE;
                        end else begin
                            state_q  <= ST_REQ;
                            sd_lba_q <= sd_lba_q + 32'd1;
                            sd_rd_q  <= op_load_q;
                            sd_wr_q  <= !op_load_q;
                            timer_q  <= ACK_TIMEOUT - 24'd1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign sd_lba      = sd_lba_q;
    assign sd_rd       = sd_rd_q;
    assign sd_wr       = sd_wr_q;
    assign sd_buff_din = ram_do;
    assign ram_addr    = ram_addr_q;
    assign ram_we      = ram_we_q;
    assign ram_di      = ram_di_q;
    assign busy        = (state_q != ST_IDLE);
    assign dirty       = dirty_q;
    assign err         = err_q;

endmodule
